// File: rtl/pc_branch_unit.sv
// Program counter, registered ALU flags and control-transfer resolution.
// A circular return-address stack serves Call/Ret; overflow overwrites the oldest entry.
module pc_branch_unit #(
  parameter int unsigned        ADDR_W    = 32,
  parameter int unsigned        RAS_DEPTH = 8,
  parameter logic [ADDR_W-1:0]  RESET_PC  = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              b,
  input  logic              br,
  input  logic              bz,
  input  logic              bnz,
  input  logic              bcy,
  input  logic              bncy,
  input  logic              bs,
  input  logic              bns,
  input  logic              bv,
  input  logic              bnv,
  input  logic              Call,
  input  logic              Ret,
  input  logic [ADDR_W-1:0] imm_offset,
  input  logic [ADDR_W-1:0] reg_target,
  input  logic              flag_we,
  input  logic              alu_zero,
  input  logic              alu_carry,
  input  logic              alu_sign,
  input  logic              alu_overflow,
  output logic [ADDR_W-1:0] pc,
  output logic [3:0]        flags,
  output logic              taken,
  output logic              ras_err
);

  localparam int unsigned       PTR_W   = $clog2(RAS_DEPTH);
  localparam int unsigned       SP_W    = PTR_W + 1;
  localparam logic [SP_W-1:0]   SP_FULL = SP_W'(RAS_DEPTH);

  typedef enum logic [2:0] {
    SRC_SEQ,
    SRC_REL,
    SRC_BR,
    SRC_CALL,
    SRC_RET,
    SRC_RET_EMPTY
  } src_e;

  logic [ADDR_W-1:0] r_pc;
  logic [3:0]        r_flags;
  logic              r_taken;
  logic              r_ras_err;
  logic [SP_W-1:0]   r_sp;
  logic [PTR_W-1:0]  r_wp;
  logic [ADDR_W-1:0] r_ras [RAS_DEPTH];

  src_e              w_src;
  logic              w_cond;
  logic              w_redirect;
  logic [ADDR_W-1:0] w_pc_inc;
  logic [ADDR_W-1:0] w_pc_rel;
  logic [ADDR_W-1:0] w_next_pc;
  logic [PTR_W-1:0]  w_wp_dec;

  assign w_pc_inc = r_pc + ADDR_W'(1);
  assign w_pc_rel = r_pc + imm_offset;
  assign w_wp_dec = r_wp - PTR_W'(1);

  // Flags are {Z,C,S,V}; conditions see the value from before this edge's flag_we.
  assign w_cond = (bz   &  r_flags[3]) | (bnz  & ~r_flags[3])
                | (bcy  &  r_flags[2]) | (bncy & ~r_flags[2])
                | (bs   &  r_flags[1]) | (bns  & ~r_flags[1])
                | (bv   &  r_flags[0]) | (bnv  & ~r_flags[0]);

  always_comb begin
    w_src = SRC_SEQ;
    if (Ret)            w_src = (r_sp == '0) ? SRC_RET_EMPTY : SRC_RET;
    else if (Call)      w_src = SRC_CALL;
    else if (br)        w_src = SRC_BR;
    else if (b | w_cond) w_src = SRC_REL;
  end

  always_comb begin
    w_next_pc = w_pc_inc;
    case (w_src)
      SRC_RET:           w_next_pc = r_ras[w_wp_dec];
      SRC_CALL, SRC_REL: w_next_pc = w_pc_rel;
      SRC_BR:            w_next_pc = reg_target;
      default:           w_next_pc = w_pc_inc;
    endcase
  end

  assign w_redirect = (w_src == SRC_RET) || (w_src == SRC_CALL) ||
                      (w_src == SRC_BR)  || (w_src == SRC_REL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc      <= RESET_PC;
      r_flags   <= '0;
      r_taken   <= 1'b0;
      r_ras_err <= 1'b0;
      r_sp      <= '0;
      r_wp      <= '0;
      for (int unsigned i = 0; i < RAS_DEPTH; i++) r_ras[i] <= '0;
    end else if (!stall) begin
      r_pc    <= w_next_pc;
      r_taken <= w_redirect;
      if (flag_we) r_flags <= {alu_zero, alu_carry, alu_sign, alu_overflow};
      // sp counts live entries; wp always advances, so a full push overwrites the oldest.
      case (w_src)
        SRC_CALL: begin
          r_ras[r_wp] <= w_pc_inc;
          r_wp        <= r_wp + PTR_W'(1);
          if (r_sp == SP_FULL) r_ras_err <= 1'b1;
          else                 r_sp      <= r_sp + SP_W'(1);
        end
        SRC_RET: begin
          r_wp <= w_wp_dec;
          r_sp <= r_sp - SP_W'(1);
        end
        SRC_RET_EMPTY: r_ras_err <= 1'b1;
        default: ;
      endcase
    end
  end

  assign pc      = r_pc;
  assign flags   = r_flags;
  assign taken   = r_taken;
  assign ras_err = r_ras_err;

endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed bench for pc_branch_unit: sequential fetch, flag-conditioned branches,
// Call/Ret with RAS overflow/underflow, stall and asynchronous reset.
module tb_pc_branch_unit;

  logic        clk, rst_n, stall;
  logic        b, br, bz, bnz, bcy, bncy, bs, bns, bv, bnv, Call, Ret;
  logic [31:0] imm_offset, reg_target;
  logic        flag_we, alu_zero, alu_carry, alu_sign, alu_overflow;
  logic [31:0] pc;
  logic [3:0]  flags;
  logic        taken, ras_err;

  int errors = 0;
  int checks = 0;

  pc_branch_unit #(.ADDR_W(32), .RAS_DEPTH(8), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .b(b), .br(br), .bz(bz), .bnz(bnz), .bcy(bcy), .bncy(bncy),
    .bs(bs), .bns(bns), .bv(bv), .bnv(bnv), .Call(Call), .Ret(Ret),
    .imm_offset(imm_offset), .reg_target(reg_target),
    .flag_we(flag_we), .alu_zero(alu_zero), .alu_carry(alu_carry),
    .alu_sign(alu_sign), .alu_overflow(alu_overflow),
    .pc(pc), .flags(flags), .taken(taken), .ras_err(ras_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout pc=%h", pc);
    $fatal(1, "timeout");
  end

  task automatic clr;
    stall = 0; b = 0; br = 0; bz = 0; bnz = 0; bcy = 0; bncy = 0;
    bs = 0; bns = 0; bv = 0; bnv = 0; Call = 0; Ret = 0;
    imm_offset = '0; reg_target = '0; flag_we = 0;
    alu_zero = 0; alu_carry = 0; alu_sign = 0; alu_overflow = 0;
  endtask

  // One clock: inputs set beforehand are sampled, then strobes are cleared.
  task automatic step;
    @(posedge clk); #1;
    clr();
  endtask

  task automatic do_reset;
    clr();
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  task automatic jump_to(input logic [31:0] tgt);
    br = 1; reg_target = tgt; step();
    if (pc !== tgt || taken !== 1'b1) begin errors++; $display("FAIL br_jump pc=%h taken=%b exp pc=%h taken=1", pc, taken, tgt); end
    checks++;
  endtask

  task automatic test_reset;
    rst_n = 0; clr(); #12;
    if (pc !== 32'h0 || flags !== 4'h0 || taken !== 1'b0 || ras_err !== 1'b0) begin
      errors++; $display("FAIL reset_state pc=%h flags=%b taken=%b err=%b exp 0/0/0/0", pc, flags, taken, ras_err);
    end
    checks++;
    @(posedge clk); #1; rst_n = 1;
    for (int i = 1; i <= 5; i++) begin
      step();
      if (pc !== 32'(i) || taken !== 1'b0 || flags !== 4'h0) begin
        errors++; $display("FAIL seq_fetch pc=%h taken=%b flags=%b exp pc=%h taken=0 flags=0", pc, taken, flags, 32'(i));
      end
      checks++;
    end
  endtask

  task automatic test_cond_branch;
    jump_to(32'd10);
    flag_we = 1; alu_zero = 1; step();
    if (pc !== 32'd11 || flags !== 4'b1000 || taken !== 1'b0) begin
      errors++; $display("FAIL flag_latch pc=%h flags=%b taken=%b exp 11/1000/0", pc, flags, taken);
    end
    checks++;
    bz = 1; imm_offset = -32'sd4; step();
    if (pc !== 32'd7 || taken !== 1'b1) begin errors++; $display("FAIL bz_taken pc=%h taken=%b exp 7/1", pc, taken); end
    checks++;
    bnz = 1; imm_offset = -32'sd4; step();
    if (pc !== 32'd8 || taken !== 1'b0) begin errors++; $display("FAIL bnz_not_taken pc=%h taken=%b exp 8/0", pc, taken); end
    checks++;
    flag_we = 1; alu_carry = 1; step();
    if (pc !== 32'd9 || flags !== 4'b0100) begin errors++; $display("FAIL flag_carry pc=%h flags=%b exp 9/0100", pc, flags); end
    checks++;
    bcy = 1; imm_offset = 32'd5; step();
    if (pc !== 32'd14 || taken !== 1'b1) begin errors++; $display("FAIL bcy_taken pc=%h taken=%b exp 14/1", pc, taken); end
    checks++;
    bz = 1; imm_offset = 32'd5; step();
    if (pc !== 32'd15 || taken !== 1'b0) begin errors++; $display("FAIL bz_clear pc=%h taken=%b exp 15/0", pc, taken); end
    checks++;
    bncy = 1; imm_offset = 32'd5; step();
    if (pc !== 32'd16 || taken !== 1'b0) begin errors++; $display("FAIL bncy_not_taken pc=%h taken=%b exp 16/0", pc, taken); end
    checks++;
    bs = 1; imm_offset = 32'd5; step();
    if (pc !== 32'd17 || taken !== 1'b0) begin errors++; $display("FAIL bs_not_taken pc=%h taken=%b exp 17/0", pc, taken); end
    checks++;
    bns = 1; imm_offset = 32'd3; step();
    if (pc !== 32'd20 || taken !== 1'b1) begin errors++; $display("FAIL bns_taken pc=%h taken=%b exp 20/1", pc, taken); end
    checks++;
    bv = 1; imm_offset = 32'd3; step();
    if (pc !== 32'd21 || taken !== 1'b0) begin errors++; $display("FAIL bv_not_taken pc=%h taken=%b exp 21/0", pc, taken); end
    checks++;
    bnv = 1; imm_offset = 32'd2; step();
    if (pc !== 32'd23 || taken !== 1'b1) begin errors++; $display("FAIL bnv_taken pc=%h taken=%b exp 23/1", pc, taken); end
    checks++;
    b = 1; imm_offset = -32'sd23; step();
    if (pc !== 32'd0 || taken !== 1'b1) begin errors++; $display("FAIL b_uncond pc=%h taken=%b exp 0/1", pc, taken); end
    checks++;
  endtask

  task automatic test_same_cycle_flags;
    // Flags are {0,1,0,0} here: Z=0 before the edge even though Z=1 is written at it.
    flag_we = 1; alu_zero = 1; bz = 1; imm_offset = 32'd16; step();
    if (pc !== 32'd1 || taken !== 1'b0 || flags !== 4'b1000) begin
      errors++; $display("FAIL bz_old_flags pc=%h taken=%b flags=%b exp 1/0/1000", pc, taken, flags);
    end
    checks++;
  endtask

  task automatic test_call_ret;
    do_reset();
    jump_to(32'h20);
    Call = 1; imm_offset = 32'h100; step();
    if (pc !== 32'h120 || taken !== 1'b1) begin errors++; $display("FAIL call pc=%h taken=%b exp 120/1", pc, taken); end
    checks++;
    Ret = 1; step();
    if (pc !== 32'h21 || taken !== 1'b1) begin errors++; $display("FAIL ret pc=%h taken=%b exp 21/1", pc, taken); end
    checks++;
    for (int i = 0; i < 3; i++) begin
      Call = 1; imm_offset = 32'h10; step();
    end
    if (pc !== 32'h51) begin errors++; $display("FAIL nested_call pc=%h exp 51", pc); end
    checks++;
    for (int i = 0; i < 3; i++) begin
      Ret = 1; step();
      if (pc !== 32'h42 - 32'(i) * 32'h10 || taken !== 1'b1) begin
        errors++; $display("FAIL nested_ret pc=%h taken=%b exp %h/1", pc, taken, 32'h42 - 32'(i) * 32'h10);
      end
      checks++;
    end
    Call = 1; imm_offset = 32'h4; step();
    Call = 1; Ret = 1; imm_offset = 32'h100; step();
    if (pc !== 32'h23 || taken !== 1'b1) begin errors++; $display("FAIL call_ret_both pc=%h taken=%b exp 23/1", pc, taken); end
    checks++;
    if (ras_err !== 1'b0) begin errors++; $display("FAIL ras_err_clean err=%b exp 0", ras_err); end
    checks++;
    Ret = 1; step();
    if (pc !== 32'h24 || taken !== 1'b0 || ras_err !== 1'b1) begin
      errors++; $display("FAIL no_push_underflow pc=%h taken=%b err=%b exp 24/0/1", pc, taken, ras_err);
    end
    checks++;
  endtask

  task automatic test_ras_overflow;
    do_reset();
    jump_to(32'h100);
    for (int k = 0; k < 9; k++) begin
      Call = 1; imm_offset = 32'h10; step();
      if (k == 7 && ras_err !== 1'b0) begin errors++; $display("FAIL ras_full_no_err err=%b exp 0", ras_err); end
      if (k == 7) checks++;
    end
    if (pc !== 32'h190 || ras_err !== 1'b1) begin
      errors++; $display("FAIL ras_overflow pc=%h err=%b exp 190/1", pc, ras_err);
    end
    checks++;
    for (int k = 8; k >= 1; k--) begin
      Ret = 1; step();
      if (pc !== 32'h101 + 32'(k) * 32'h10 || taken !== 1'b1) begin
        errors++; $display("FAIL ras_pop pc=%h taken=%b exp %h/1", pc, taken, 32'h101 + 32'(k) * 32'h10);
      end
      checks++;
    end
    Ret = 1; step();
    if (pc !== 32'h112 || taken !== 1'b0 || ras_err !== 1'b1) begin
      errors++; $display("FAIL ras_underflow pc=%h taken=%b err=%b exp 112/0/1", pc, taken, ras_err);
    end
    checks++;
  endtask

  task automatic test_wrap;
    jump_to(32'hFFFF_FFFF);
    step();
    if (pc !== 32'h0 || taken !== 1'b0) begin errors++; $display("FAIL pc_wrap pc=%h taken=%b exp 0/0", pc, taken); end
    checks++;
  endtask

  task automatic test_stall;
    do_reset();
    flag_we = 1; alu_sign = 1; step();
    stall = 1; b = 1; imm_offset = 32'd50; flag_we = 1; alu_zero = 1; step();
    if (pc !== 32'd1 || flags !== 4'b0010 || taken !== 1'b0) begin
      errors++; $display("FAIL stall_hold pc=%h flags=%b taken=%b exp 1/0010/0", pc, flags, taken);
    end
    checks++;
    b = 1; imm_offset = 32'd5; step();
    stall = 1; Ret = 1; step();
    if (pc !== 32'd6 || taken !== 1'b1 || ras_err !== 1'b0) begin
      errors++; $display("FAIL stall_taken_hold pc=%h taken=%b err=%b exp 6/1/0", pc, taken, ras_err);
    end
    checks++;
  endtask

  task automatic test_async_reset;
    do_reset();
    Call = 1; imm_offset = 32'h40; step();
    Call = 1; imm_offset = 32'h40;
    #2 rst_n = 0;
    #1;
    if (pc !== 32'h0 || taken !== 1'b0 || ras_err !== 1'b0) begin
      errors++; $display("FAIL async_reset pc=%h taken=%b err=%b exp 0/0/0", pc, taken, ras_err);
    end
    checks++;
    clr();
    @(posedge clk); #1; rst_n = 1;
    Ret = 1; step();
    if (pc !== 32'h1 || taken !== 1'b0 || ras_err !== 1'b1) begin
      errors++; $display("FAIL post_reset_sp0 pc=%h taken=%b err=%b exp 1/0/1", pc, taken, ras_err);
    end
    checks++;
  endtask

  initial begin
    test_reset();
    test_cond_branch();
    test_same_cycle_flags();
    test_call_ret();
    test_ras_overflow();
    test_wrap();
    test_stall();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
